// File: rtl/irq_pkg.sv
// Shared types for the interrupt entry/return unit.
package irq_pkg;

  // Condition-code width.
  localparam int unsigned CC_W = 4;

  // Default core address width; the top rebuilds the context type at its own AW.
  localparam int unsigned CTX_AW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } state_t;

  // Saved return context.
  typedef struct packed {
    logic [CTX_AW-1:0] pc;
    logic [CC_W-1:0]   ccodes;
  } ctx_t;

endpackage

// File: rtl/ctx_stack.sv
// Hardware LIFO of return contexts. Only the pointer is reset; entries are not
// cleared on pop, the pointer simply moves back over them.
module ctx_stack
  import irq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter type         ctx_el_t = ctx_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  ctx_el_t                    din,
  output ctx_el_t                    dout,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ctx_el_t       mem_q [DEPTH];
  logic [DW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign full    = (ptr_q == DW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign depth   = ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign wr_idx  = IW'(ptr_q);
  // Top of stack; value is meaningless while empty.
  assign rd_idx  = IW'(ptr_q - 1'b1);
  assign dout    = mem_q[rd_idx];

  // Pointer next state: push wins if a caller ever asserts both.
  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Entry storage, written on push only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/irq_entry_unit.sv
// CPU-side interrupt entry/return sequencer: takes the VIC redirect, flushes,
// saves {PC, CCodes} on a LIFO, steers to the vector and acks; reti restores.
module irq_entry_unit
  import irq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_irq_req,
  input  logic [AW-1:0]              i_irq_vec,
  output logic                       o_irq_ack,
  input  logic [AW-1:0]              i_PC,
  input  logic [CC_W-1:0]            i_CCodes,
  input  logic                       i_PC_stall,
  input  logic                       i_reti,
  output logic                       o_PC_ctrl,
  output logic [AW-1:0]              o_PC_next,
  output logic [CC_W-1:0]            o_CCodes,
  output logic                       o_CCodes_we,
  output logic                       o_Flush,
  output logic                       o_in_isr,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_err
);

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [CC_W-1:0] ccodes;
  } ctx_aw_t;

  state_t        state_q, state_d;
  logic [AW-1:0] vec_q, vec_d;
  ctx_aw_t       ret_q, ret_d;
  logic          err_q, err_d;

  logic    push, pop, full, empty;
  ctx_aw_t push_ctx, top_ctx;

  assign push_ctx = '{pc: i_PC, ccodes: i_CCodes};

  ctx_stack #(
    .DEPTH    (DEPTH),
    .ctx_el_t (ctx_aw_t)
  ) u_ctx_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_ctx),
    .dout  (top_ctx),
    .depth (o_depth),
    .full  (full),
    .empty (empty)
  );

  // Next-state: reti beats a request in IDLE; FLUSH ignores reti since it is flushed.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ret_d   = ret_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_reti) begin
          if (!empty) begin
            pop     = 1'b1;
            ret_d   = top_ctx;
            state_d = RETURN;
          end else begin
            err_d = 1'b1;
          end
        end else if (i_irq_req && !i_PC_stall && !full) begin
          push    = 1'b1;
          vec_d   = i_irq_vec;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = VECTOR;
      end
      VECTOR: begin
        if (!i_PC_stall) state_d = IDLE;
      end
      RETURN: begin
        if (!i_PC_stall) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      ret_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

  // Output decode from state; only ack/CCodes_we look at the live stall.
  always_comb begin
    o_irq_ack   = 1'b0;
    o_PC_ctrl   = 1'b0;
    o_PC_next   = '0;
    o_CCodes    = '0;
    o_CCodes_we = 1'b0;
    o_Flush     = 1'b0;
    unique case (state_q)
      FLUSH: begin
        o_Flush = 1'b1;
      end
      VECTOR: begin
        o_PC_ctrl = 1'b1;
        o_PC_next = vec_q;
        o_irq_ack = !i_PC_stall;
      end
      RETURN: begin
        o_PC_ctrl   = 1'b1;
        o_PC_next   = ret_q.pc;
        o_CCodes    = ret_q.ccodes;
        o_Flush     = 1'b1;
        o_CCodes_we = !i_PC_stall;
      end
      default: ;
    endcase
  end

  assign o_in_isr = !empty;
  assign o_err    = err_q;

endmodule

// File: doc/irq_entry_unit.md
# irq_entry_unit

CPU-side responder to the vectored interrupt controller. It accepts the VIC's PC-redirect request, flushes the pipeline and saves the return context (PC and condition codes) on a small hardware LIFO. It then steers the PC to the ISR vector and acknowledges the VIC. On `reti` it pops the context and restores PC and condition codes. It sits between the VIC outputs and the fetch/execute stages of the core.

## Interface
- `DEPTH`, 4: maximum interrupt nesting depth (context stack entries).
- `AW`, 32: PC/address width.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_irq_req`  in  1  VIC redirect request; held high until acknowledged.
- `i_irq_vec`  in  AW  ISR address from VIC; valid while `i_irq_req`.
- `o_irq_ack`  out  1  one-cycle pulse: vector taken.
- `i_PC`  in  AW  address of next instruction to execute (return address).
- `i_CCodes`  in  4  current condition codes.
- `i_PC_stall`  in  1  pipeline stall; PC cannot be redirected.
- `i_reti`  in  1  one-cycle pulse, `reti` decoded in execute.
- `o_PC_ctrl`  out  1  select `o_PC_next` into the PC.
- `o_PC_next`  out  AW  redirect target.
- `o_CCodes`  out  4  restored condition codes.
- `o_CCodes_we`  out  1  write `o_CCodes` into the flag register.
- `o_Flush`  out  1  flush fetch/decode stages.
- `o_in_isr`  out  1  stack depth nonzero.
- `o_depth`  out  $clog2(DEPTH+1)  current stack depth.
- `o_err`  out  1  sticky: `reti` with empty stack.

## Operation
- FSM states: IDLE, FLUSH, VECTOR, RETURN.
- **IDLE**
  - `reti` has priority. If `i_reti=1` and depth>0: pop the stack, latch the popped context, go to RETURN.
  - If `i_reti=1` and depth=0: no pop, set `o_err`, stay in IDLE.
  - Otherwise, if `i_irq_req=1`, `i_PC_stall=0` and depth<DEPTH:
    - push {`i_PC`, `i_CCodes`};
    - latch `i_irq_vec`;
    - go to FLUSH.
  - Request with depth=DEPTH: not accepted, no error. The request stays pending until a `reti` frees a slot.
- **FLUSH**
  - `o_Flush=1` for exactly one cycle, then go to VECTOR.
  - `i_reti` is ignored in this state, because the flush discards it.
- **VECTOR**
  - `o_PC_ctrl=1`, `o_PC_next`=latched vector.
  - If `i_PC_stall=0`: `o_irq_ack=1` this cycle, then go to IDLE.
  - If stalled: hold the outputs with `o_irq_ack=0`.
- **RETURN**
  - `o_PC_ctrl=1`, `o_PC_next`=popped PC, `o_CCodes`=popped codes, `o_Flush=1`.
  - If `i_PC_stall=0`: `o_CCodes_we=1`, then go to IDLE.
  - If stalled: hold the outputs with `o_CCodes_we=0`.
- Nesting: a new request is accepted in IDLE while depth>0. Stack order is strict LIFO.
- `o_in_isr = (depth != 0)`.
- Push and pop never happen in the same cycle.
- Stack contents are not cleared on pop. Only the pointer moves.

## Timing
- Reset values:
  - state IDLE; depth 0; `o_err` 0;
  - `o_irq_ack`, `o_PC_ctrl`, `o_CCodes_we`, `o_Flush`, `o_in_isr` all 0;
  - `o_PC_next` 0; `o_CCodes` 0.
- All outputs are registered-state decodes, never combinational from the inputs. The one exception is the stall gating of `o_irq_ack` and `o_CCodes_we`.
- Interrupt entry: accept at cycle T → `o_Flush` at T+1 → `o_PC_ctrl` and `o_irq_ack` at T+2 (no stall). Minimum latency is 2 cycles.
- Return: `i_reti` at T → RETURN outputs at T+1. Minimum latency is 1 cycle.
- `o_depth` updates the cycle after the push or pop.
- Back-to-back: IDLE is entered for at least one cycle between events. The VIC request is sampled no earlier than the cycle after `o_irq_ack`.
- Reset in any state aborts the operation the same cycle and empties the stack. No ack is issued.

## Structure
- Package `irq_pkg`:
  - `state_t` enum {IDLE, FLUSH, VECTOR, RETURN};
  - `ctx_t` struct {pc[AW-1:0], ccodes[3:0]};
  - constant `CC_W=4`.
- Sub-module `ctx_stack`:
  - parameterised LIFO of `ctx_t`, DEPTH entries;
  - ports: push, pop, din, dout, depth, full, empty;
  - synchronous reset of the pointer only.
- FSM and output decode live in `irq_entry_unit`.

## Test plan
- Single interrupt: `i_irq_req=1`, `i_irq_vec=0x100`, `i_PC=0x40`, `i_CCodes=0xA`, no stall → `o_Flush` at T+1; `o_PC_ctrl=1`, `o_PC_next=0x100`, `o_irq_ack=1` at T+2; `o_depth=1`. Then `i_reti` → next cycle `o_PC_next=0x40`, `o_CCodes=0xA`, `o_CCodes_we=1`; `o_depth=0`.
- Stall in VECTOR: 3 stall cycles → `o_PC_ctrl` held for 4 cycles, `o_irq_ack` only in the 4th.
- Nesting to full (DEPTH=4):
  - 4 requests with PCs 0x10, 0x20, 0x30, 0x40 → depth 4; a 5th request gets no ack while pending.
  - First `reti` returns 0x40; the pending request is then accepted.
  - Afterwards, pops return in LIFO order.
- Underflow: `i_reti` with depth 0 → `o_err=1` sticky, no `o_PC_ctrl`. Only `rst` clears it.
- Simultaneous `i_reti` and `i_irq_req` in IDLE at depth 1 → RETURN taken first; the request is accepted on the following IDLE cycle.
- Reset during FLUSH → next cycle all outputs 0, depth 0, no ack.
